hyperram_txn_scheduler: RTL and testbench

- Sequences and shares the HyperRAM PHY, which drives CS/CK/CK_n/RWDS/DQ.
- After reset it runs device bring-up: power-up wait, hardware reset pulse, CR0 configuration write, and ID0 read-back check.
- It then arbitrates round-robin between two requesters and issues one transaction at a time as a 48-bit CA word plus burst length over a req/ack/done PHY handshake.
- It routes write and read data between the PHY and the granted requester.

---
 rtl/hyperram_txn_scheduler.sv | 222 ++++++++++++++++++++++
 tb/tb_hyperram_txn_scheduler.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hyperram_txn_scheduler.sv
// HyperRAM bring-up sequencer and two-way round-robin transaction scheduler in front of the PHY.
// Grant one cycle after valid in IDLE; phy_req held until phy_ack; data paths are zero-latency pass-through.
module hyperram_txn_scheduler #(
    parameter int unsigned PWRUP_CYCLES       = 30000,
    parameter int unsigned RST_PULSE_CYCLES   = 40,
    parameter int unsigned RST_RECOVER_CYCLES = 80,
    parameter logic [15:0] CR0_VALUE          = 16'h8F1F,
    parameter logic [47:0] CR0_CA             = 48'h6000_0100_0000,
    parameter logic [47:0] ID0_CA             = 48'hE000_0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        hr_rst_n,
    output logic        init_done,
    output logic        init_error,
    output logic [15:0] id0_value,
    output logic        busy,
    output logic        phy_req,
    output logic [47:0] phy_ca,
    output logic [7:0]  phy_len,
    input  logic        phy_ack,
    input  logic        phy_done,
    output logic [15:0] phy_wdata,
    input  logic        phy_wready,
    input  logic [15:0] phy_rdata,
    input  logic        phy_rvalid,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic        req0_write,
    input  logic [31:0] req0_addr,
    input  logic [7:0]  req0_len,
    input  logic [15:0] req0_wdata,
    output logic        req0_wready,
    output logic [15:0] req0_rdata,
    output logic        req0_rvalid,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic        req1_write,
    input  logic [31:0] req1_addr,
    input  logic [7:0]  req1_len,
    input  logic [15:0] req1_wdata,
    output logic        req1_wready,
    output logic [15:0] req1_rdata,
    output logic        req1_rvalid
);

    typedef enum logic [3:0] {
        S_PWRUP, S_RST_ASSERT, S_RST_RECOVER, S_CFG_WR, S_CFG_WAIT,
        S_ID_RD, S_ID_CHK, S_ERROR, S_IDLE, S_ISSUE, S_DATA
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic        last_grant_q, last_grant_d;
    logic        grant_q, grant_d;
    logic        id_acked_q, id_acked_d;
    logic        id_got_q, id_got_d;
    logic [15:0] id0_q, id0_d;
    logic        init_done_q, init_done_d;
    logic        init_error_q, init_error_d;
    logic [47:0] ca_q, ca_d;
    logic [7:0]  len_q, len_d;

    // Tie goes to the requester that did not win last time.
    logic        sel_c;
    logic        sel_write_c;
    logic [31:0] sel_addr_c;
    logic [7:0]  sel_len_c;
    assign sel_c       = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
    assign sel_write_c = sel_c ? req1_write : req0_write;
    assign sel_addr_c  = sel_c ? req1_addr  : req0_addr;
    assign sel_len_c   = sel_c ? req1_len   : req0_len;

    logic xfer_c;
    assign xfer_c = (state_q == S_ISSUE) || (state_q == S_DATA);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        id_acked_d   = id_acked_q;
        id_got_d     = id_got_q;
        id0_d        = id0_q;
        init_done_d  = init_done_q;
        init_error_d = init_error_q;
        ca_d         = ca_q;
        len_d        = len_q;
        phy_req      = 1'b0;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;
        case (state_q)
            S_PWRUP: begin
                if (cnt_q == PWRUP_CYCLES - 1) begin
                    state_d = S_RST_ASSERT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_RST_ASSERT: begin
                if (cnt_q == RST_PULSE_CYCLES - 1) begin
                    state_d = S_RST_RECOVER;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_RST_RECOVER: begin
                if (cnt_q == RST_RECOVER_CYCLES - 1) begin
                    state_d = S_CFG_WR;
                    cnt_d   = '0;
                    ca_d    = CR0_CA;
                    len_d   = 8'd1;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_CFG_WR, S_CFG_WAIT: begin
                phy_req = (state_q == S_CFG_WR);
                if (phy_done) begin
                    state_d    = S_ID_RD;
                    ca_d       = ID0_CA;
                    len_d      = 8'd1;
                    id_acked_d = 1'b0;
                    id_got_d   = 1'b0;
                end else if (phy_ack && state_q == S_CFG_WR) begin
                    state_d = S_CFG_WAIT;
                end
            end
            S_ID_RD: begin
                phy_req = ~id_acked_q;
                if (phy_ack) id_acked_d = 1'b1;
                if (phy_rvalid && !id_got_q) begin
                    id0_d    = phy_rdata;
                    id_got_d = 1'b1;
                end
                if (phy_done) state_d = S_ID_CHK;
            end
            S_ID_CHK: begin
                if (id0_q == 16'h0000 || id0_q == 16'hFFFF) begin
                    init_error_d = 1'b1;
                    state_d      = S_ERROR;
                end else begin
                    init_done_d = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            S_IDLE: begin
                if (req0_valid || req1_valid) begin
                    grant_d = sel_c;
                    ca_d    = {~sel_write_c, 1'b0, 1'b1, sel_addr_c[31:3], 13'd0, sel_addr_c[2:0]};
                    len_d   = (sel_len_c == 8'd0) ? 8'd1 : sel_len_c;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                phy_req = 1'b1;
                if (phy_ack) begin
                    req0_ready   = ~grant_q;
                    req1_ready   = grant_q;
                    last_grant_d = grant_q;
                    state_d      = phy_done ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (phy_done) state_d = S_IDLE;
            end
            default: state_d = S_ERROR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_PWRUP;
            cnt_q        <= '0;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            id_acked_q   <= 1'b0;
            id_got_q     <= 1'b0;
            id0_q        <= '0;
            init_done_q  <= 1'b0;
            init_error_q <= 1'b0;
            ca_q         <= '0;
            len_q        <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            id_acked_q   <= id_acked_d;
            id_got_q     <= id_got_d;
            id0_q        <= id0_d;
            init_done_q  <= init_done_d;
            init_error_q <= init_error_d;
            ca_q         <= ca_d;
            len_q        <= len_d;
        end
    end

    assign hr_rst_n   = (state_q != S_RST_ASSERT);
    assign init_done  = init_done_q;
    assign init_error = init_error_q;
    assign id0_value  = id0_q;
    assign busy       = xfer_c;
    assign phy_ca     = ca_q;
    assign phy_len    = len_q;

    always_comb begin
        phy_wdata = 16'd0;
        if (state_q == S_CFG_WR || state_q == S_CFG_WAIT) phy_wdata = CR0_VALUE;
        else if (xfer_c) phy_wdata = grant_q ? req1_wdata : req0_wdata;
    end

    assign req0_wready = xfer_c && phy_wready && !grant_q;
    assign req1_wready = xfer_c && phy_wready &&  grant_q;
    assign req0_rvalid = xfer_c && phy_rvalid && !grant_q;
    assign req1_rvalid = xfer_c && phy_rvalid &&  grant_q;
    assign req0_rdata  = (xfer_c && !grant_q) ? phy_rdata : 16'd0;
    assign req1_rdata  = (xfer_c &&  grant_q) ? phy_rdata : 16'd0;

endmodule

// File: tb/tb_hyperram_txn_scheduler.sv
// Directed bench: bring-up timing, arbitration, table-driven bursts, mid-transfer reset, ID failure.
module tb_hyperram_txn_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        hr_rst_n, init_done, init_error, busy, phy_req;
    logic [15:0] id0_value, phy_wdata;
    logic [47:0] phy_ca;
    logic [7:0]  phy_len;
    logic        phy_ack, phy_done, phy_wready, phy_rvalid;
    logic [15:0] phy_rdata;
    logic        req0_valid, req0_ready, req0_write, req0_wready, req0_rvalid;
    logic [31:0] req0_addr;
    logic [7:0]  req0_len;
    logic [15:0] req0_wdata, req0_rdata;
    logic        req1_valid, req1_ready, req1_write, req1_wready, req1_rvalid;
    logic [31:0] req1_addr;
    logic [7:0]  req1_len;
    logic [15:0] req1_wdata, req1_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hyperram_txn_scheduler #(
        .PWRUP_CYCLES(10), .RST_PULSE_CYCLES(4), .RST_RECOVER_CYCLES(6)
    ) dut (
        .clk(clk), .rst_n(rst_n), .hr_rst_n(hr_rst_n), .init_done(init_done),
        .init_error(init_error), .id0_value(id0_value), .busy(busy),
        .phy_req(phy_req), .phy_ca(phy_ca), .phy_len(phy_len), .phy_ack(phy_ack),
        .phy_done(phy_done), .phy_wdata(phy_wdata), .phy_wready(phy_wready),
        .phy_rdata(phy_rdata), .phy_rvalid(phy_rvalid),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_write(req0_write),
        .req0_addr(req0_addr), .req0_len(req0_len), .req0_wdata(req0_wdata),
        .req0_wready(req0_wready), .req0_rdata(req0_rdata), .req0_rvalid(req0_rvalid),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_write(req1_write),
        .req1_addr(req1_addr), .req1_len(req1_len), .req1_wdata(req1_wdata),
        .req1_wready(req1_wready), .req1_rdata(req1_rdata), .req1_rvalid(req1_rvalid)
    );

    typedef struct {
        int          n;
        logic        wr;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [47:0] eca;
        logic [7:0]  elen;
        logic [15:0] base;
    } vec_t;

    vec_t tbl[4];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive_req(input int n, input logic v, input logic wr,
                             input logic [31:0] a, input logic [7:0] l);
        if (n == 1) begin
            req1_valid = v; req1_write = wr; req1_addr = a; req1_len = l;
        end else begin
            req0_valid = v; req0_write = wr; req0_addr = a; req0_len = l;
        end
    endtask

    function automatic logic rdy_of(input int n);
        return (n == 1) ? req1_ready : req0_ready;
    endfunction

    // Called at a negedge; returns at the negedge where phy_req is seen.
    task automatic wait_req(output bit ok, output int waited);
        ok = 0;
        waited = 0;
        for (int k = 0; k < 20 && !ok; k++) begin
            #1;
            if (phy_req === 1'b1) ok = 1;
            else begin
                waited++;
                @(negedge clk);
            end
        end
        if (!ok) chk("phy_req_timeout", 0, 1);
    endtask

    task automatic bringup(input logic [15:0] idw, input logic ok);
        @(negedge clk);
        rst_n = 1'b0;
        phy_ack = 0; phy_done = 0; phy_rvalid = 0; phy_rdata = 0; phy_wready = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 28; i++) begin
            phy_ack    = (i == 20 || i == 23);
            phy_done   = (i == 22 || i == 25);
            phy_rvalid = (i == 24);
            phy_rdata  = (i == 24) ? idw : 16'h0;
            #1;
            if (i == 0) begin
                chk("rst_init_done", init_done, 0);
                chk("rst_init_error", init_error, 0);
                chk("rst_busy", busy, 0);
                chk("rst_phy_req", phy_req, 0);
                chk("rst_id0", id0_value, 0);
                chk("rst_phy_ca", phy_ca, 0);
                chk("rst_phy_len", phy_len, 0);
                chk("rst_phy_wdata", phy_wdata, 0);
                chk("rst_ready", {req0_ready, req1_ready, req0_rvalid, req1_rvalid}, 0);
            end
            if (i < 16) chk("hr_rst_n_timing", hr_rst_n, !(i >= 10 && i < 14));
            if (i == 19) chk("cfg_req_early", phy_req, 0);
            if (i == 20) begin
                chk("cfg_req", phy_req, 1);
                chk("cfg_ca", phy_ca, 48'h6000_0100_0000);
                chk("cfg_len", phy_len, 1);
                chk("cfg_wdata", phy_wdata, 16'h8F1F);
            end
            if (i == 21) chk("cfg_wait_req", phy_req, 0);
            if (i == 23) begin
                chk("id_req", phy_req, 1);
                chk("id_ca", phy_ca, 48'hE000_0000_0000);
                chk("id_len", phy_len, 1);
            end
            if (i == 24) begin
                chk("id_req_dropped", phy_req, 0);
                chk("id_rvalid_hidden", {req0_rvalid, req1_rvalid}, 0);
            end
            if (i == 26) begin
                chk("id_chk_not_done", init_done, 0);
                chk("id0_value", id0_value, idw);
            end
            if (i == 27) begin
                chk("init_done", init_done, ok);
                chk("init_error", init_error, !ok);
                chk("id0_value_held", id0_value, idw);
            end
            @(negedge clk);
        end
        phy_ack = 0; phy_done = 0; phy_rvalid = 0; phy_rdata = 0;
    endtask

    task automatic txn(input vec_t v);
        bit ok;
        int waited;
        int o;
        o = 1 - v.n;
        @(negedge clk);
        drive_req(v.n, 1'b1, v.wr, v.addr, v.len);
        @(negedge clk);
        wait_req(ok, waited);
        if (ok) begin
            chk("grant_latency", waited, 0);
            chk("txn_ca", phy_ca, v.eca);
            chk("txn_len", phy_len, v.elen);
            chk("txn_busy", busy, 1);
            chk("ready_before_ack", rdy_of(v.n), 0);
            phy_ack = 1'b1;
            #1;
            chk("ready_on_ack", rdy_of(v.n), 1);
            chk("other_ready", rdy_of(o), 0);
            @(negedge clk);
            phy_ack = 1'b0;
            drive_req(v.n, 1'b0, 1'b0, 32'h0, 8'h0);
            for (int b = 0; b < int'(v.elen); b++) begin
                if (v.n == 1) begin req1_wdata = v.base + 16'(b); req0_wdata = 16'hDEAD; end
                else begin req0_wdata = v.base + 16'(b); req1_wdata = 16'hDEAD; end
                phy_wready = 1'b0;
                phy_rvalid = 1'b0;
                #1;
                chk("no_beat_wready", {req0_wready, req1_wready}, 0);
                @(negedge clk);
                if (v.wr) phy_wready = 1'b1;
                else begin phy_rvalid = 1'b1; phy_rdata = v.base + 16'(b); end
                #1;
                if (v.wr) begin
                    chk("phy_wdata", phy_wdata, v.base + 16'(b));
                    chk("wready_granted", (v.n == 1) ? req1_wready : req0_wready, 1);
                    chk("wready_other", (v.n == 1) ? req0_wready : req1_wready, 0);
                end else begin
                    chk("rdata_granted", (v.n == 1) ? req1_rdata : req0_rdata, v.base + 16'(b));
                    chk("rvalid_granted", (v.n == 1) ? req1_rvalid : req0_rvalid, 1);
                    chk("rvalid_other", (v.n == 1) ? req0_rvalid : req1_rvalid, 0);
                end
                @(negedge clk);
            end
            phy_wready = 1'b0;
            phy_rvalid = 1'b0;
            phy_done   = 1'b1;
            @(negedge clk);
            phy_done = 1'b0;
            #1;
            chk("busy_after_done", busy, 0);
            chk("req_after_done", phy_req, 0);
        end
        drive_req(v.n, 1'b0, 1'b0, 32'h0, 8'h0);
    endtask

    initial begin
        bit ok;
        int waited;
        int eg;
        int rdy_cnt;
        rst_n = 1'b0;
        phy_ack = 0; phy_done = 0; phy_wready = 0; phy_rdata = 0; phy_rvalid = 0;
        req0_valid = 0; req0_write = 0; req0_addr = 0; req0_len = 0; req0_wdata = 0;
        req1_valid = 0; req1_write = 0; req1_addr = 0; req1_len = 0; req1_wdata = 0;

        tbl[0] = '{1, 1'b1, 32'h0000_1234, 8'd4,   48'h2000_0246_0004, 8'd4,   16'h00A0};
        tbl[1] = '{0, 1'b0, 32'h0000_0010, 8'd0,   48'hA000_0002_0000, 8'd1,   16'h0F76};
        tbl[2] = '{0, 1'b1, 32'hFFFF_FFFF, 8'd255, 48'h3FFF_FFFF_0007, 8'd255, 16'h1000};
        tbl[3] = '{1, 1'b0, 32'h0000_0008, 8'd1,   48'hA000_0001_0000, 8'd1,   16'h5A5A};

        bringup(16'h0C81, 1'b1);

        // Both requesters valid throughout: grants must alternate starting with req0.
        @(negedge clk);
        drive_req(0, 1'b1, 1'b0, 32'h0000_0100, 8'd1);
        drive_req(1, 1'b1, 1'b0, 32'h0000_0200, 8'd1);
        @(negedge clk);
        for (int g = 0; g < 4; g++) begin
            eg = g % 2;
            wait_req(ok, waited);
            if (!ok) break;
            chk("arb_ca", phy_ca, (eg == 1) ? 48'hA000_0040_0000 : 48'hA000_0020_0000);
            @(negedge clk);
            @(negedge clk);
            phy_ack = 1'b1;
            #1;
            chk("arb_ready_grant", rdy_of(eg), 1);
            chk("arb_ready_other", rdy_of(1 - eg), 0);
            @(negedge clk);
            phy_ack = 1'b0;
            for (int c = 0; c < 4; c++) @(negedge clk);
            phy_done = 1'b1;
            @(negedge clk);
            phy_done = 1'b0;
            if (g == 3) begin
                req0_valid = 1'b0;
                req1_valid = 1'b0;
            end
            #1;
            chk("arb_no_req_in_done_cycle", phy_req, 0);
            @(negedge clk);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        for (int t = 0; t < 4; t++) txn(tbl[t]);

        // Reset in the middle of a data phase, with done/rvalid in flight.
        @(negedge clk);
        drive_req(0, 1'b1, 1'b0, 32'h0000_0010, 8'd2);
        @(negedge clk);
        wait_req(ok, waited);
        phy_ack = 1'b1;
        @(negedge clk);
        phy_ack = 1'b0;
        drive_req(0, 1'b0, 1'b0, 32'h0, 8'h0);
        #1;
        chk("mid_busy_before", busy, 1);
        rst_n = 1'b0;
        phy_done = 1'b1;
        phy_rvalid = 1'b1;
        phy_rdata = 16'h1234;
        @(negedge clk);
        #1;
        chk("mid_phy_req", phy_req, 0);
        chk("mid_busy", busy, 0);
        chk("mid_rvalid", req0_rvalid, 0);
        chk("mid_init_done", init_done, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 14; i++) begin
            if (i == 1) begin phy_done = 1'b0; phy_rvalid = 1'b0; end
            #1;
            chk("mid_pwrup_hr_rst_n", hr_rst_n, !(i >= 10));
            chk("mid_pwrup_req", phy_req, 0);
            @(negedge clk);
        end

        // ID check failure leaves the block locked out.
        bringup(16'hFFFF, 1'b0);
        drive_req(0, 1'b1, 1'b0, 32'h0000_0040, 8'd1);
        rdy_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (req0_ready || phy_req) rdy_cnt++;
            @(negedge clk);
        end
        chk("error_no_grant", rdy_cnt, 0);
        chk("error_sticky", init_error, 1);
        drive_req(0, 1'b0, 1'b0, 32'h0, 8'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
